// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states and the MEM/WB record.
// The bubble constant is what writeback sees whenever an instruction must not retire.
package mem_stage_pkg;

    localparam logic [3:0] MOV_WORD = 4'b0000;
    localparam logic [3:0] MOV_LBU  = 4'b0001;
    localparam logic [3:0] MOV_LB   = 4'b0010;
    localparam logic [3:0] MOV_SB   = 4'b0011;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        r15;
        logic [15:0] wb_data;
        logic [15:0] remainder;
        logic [3:0]  reg_rd;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

    // Reserved movOp codes fall through to word behaviour everywhere.
    function automatic logic is_byte_op(input logic [3:0] mov_op);
        return (mov_op == MOV_LBU) || (mov_op == MOV_LB) || (mov_op == MOV_SB);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: byte enables, store replication, load alignment/extension
// and word-misalignment detection, all keyed on movOp and the address LSB (1 = high lane).
module mem_byte_lane
    import mem_stage_pkg::*;
(
    input  logic [3:0]  mov_op,
    input  logic        addr_lsb,
    input  logic [15:0] store_data,
    input  logic [15:0] rdata,
    output logic [1:0]  be,
    output logic [15:0] wdata,
    output logic [15:0] load_data,
    output logic        misaligned
);

    logic       byte_op;
    logic [7:0] lane_byte;

    always_comb begin
        byte_op    = is_byte_op(mov_op);
        lane_byte  = addr_lsb ? rdata[15:8] : rdata[7:0];
        be         = byte_op ? (addr_lsb ? 2'b10 : 2'b01) : 2'b11;
        // SB drives both lanes so the memory can pick whichever byte enable is set.
        wdata      = (mov_op == MOV_SB) ? {2{store_data[7:0]}} : store_data;
        misaligned = ~byte_op & addr_lsb;
        case (mov_op)
            MOV_LBU: load_data = {8'h00, lane_byte};
            MOV_LB:  load_data = {{8{lane_byte[7]}}, lane_byte};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage of the 16-bit pipeline: issues req/ack data-memory accesses, stalls upstream while
// an access is outstanding, aborts on timeout and registers the MEM/WB outputs.
module mem_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MemtoReg_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        R15_in,
    input  logic        RegWrite_in,
    input  logic [15:0] ALU_Result_in,
    input  logic [15:0] ALU_Remainder_in,
    input  logic [15:0] StoreData_in,
    input  logic [3:0]  movOp_in,
    input  logic [3:0]  EXM_RegRD_in,
    input  logic        FLUSH_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [14:0] dmem_addr,
    output logic [1:0]  dmem_be,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        Stall_MEM,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        R15_out,
    output logic [15:0] WB_Data_out,
    output logic [15:0] Remainder_out,
    output logic [3:0]  MEMWB_RegRD_out,
    output logic        misalign_err,
    output logic        bus_err
);

    state_t             state;
    logic [CNT_W-1:0]   timeout_cnt;
    logic               flush_pending;
    memwb_t             memwb_q;
    memwb_t             memwb_next;

    logic               memop;
    logic               is_load;
    logic               timed_out;
    logic               access_done;
    logic               squash;
    logic [15:0]        load_data;
    logic               misaligned;

    mem_byte_lane u_lane (
        .mov_op     (movOp_in),
        .addr_lsb   (ALU_Result_in[0]),
        .store_data (StoreData_in),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign dmem_we   = MemWrite_in;
    assign dmem_addr = ALU_Result_in[15:1];

    // A flush seen while idle suppresses the request entirely; once BUSY the access must finish.
    always_comb begin
        memop       = MemRead_in | MemWrite_in;
        is_load     = MemRead_in & ~MemWrite_in;
        dmem_req    = memop & ((state == BUSY) | ~FLUSH_MEM);
        timed_out   = (state == BUSY) & dmem_req & ~dmem_ack
                      & (timeout_cnt == CNT_W'(TIMEOUT_CYCLES));
        access_done = dmem_req & dmem_ack;
        Stall_MEM   = dmem_req & ~dmem_ack & ~timed_out;
        squash      = Stall_MEM | timed_out | FLUSH_MEM | flush_pending;

        memwb_next  = MEMWB_BUBBLE;
        if (!squash) begin
            memwb_next.reg_write  = RegWrite_in;
            memwb_next.mem_to_reg = MemtoReg_in;
            memwb_next.r15        = R15_in;
            memwb_next.wb_data    = (is_load & MemtoReg_in) ? load_data : ALU_Result_in;
            memwb_next.remainder  = ALU_Remainder_in;
            memwb_next.reg_rd     = EXM_RegRD_in;
        end
    end

    // FSM, timeout counter, deferred flush and the MEM/WB register; error flags are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timeout_cnt   <= '0;
            flush_pending <= 1'b0;
            memwb_q       <= MEMWB_BUBBLE;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            memwb_q      <= memwb_next;
            misalign_err <= access_done & misaligned;
            bus_err      <= timed_out;
            case (state)
                IDLE: begin
                    if (Stall_MEM) begin
                        state       <= BUSY;
                        timeout_cnt <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (Stall_MEM) begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                        if (FLUSH_MEM) begin
                            flush_pending <= 1'b1;
                        end
                    end else begin
                        state         <= IDLE;
                        timeout_cnt   <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign RegWrite_out    = memwb_q.reg_write;
    assign MemtoReg_out    = memwb_q.mem_to_reg;
    assign R15_out         = memwb_q.r15;
    assign WB_Data_out     = memwb_q.wb_data;
    assign Remainder_out   = memwb_q.remainder;
    assign MEMWB_RegRD_out = memwb_q.reg_rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scenario-driven bench for mem_wb_stage with randomized traffic checked against an
// arithmetic model of load alignment, byte enables and the stall/timeout timeline.
module tb_mem_wb_stage;

    logic        clk, rst;
    logic        MemtoReg_in, MemWrite_in, MemRead_in, R15_in, RegWrite_in;
    logic [15:0] ALU_Result_in, ALU_Remainder_in, StoreData_in;
    logic [3:0]  movOp_in, EXM_RegRD_in;
    logic        FLUSH_MEM;
    logic        dmem_req, dmem_we;
    logic [14:0] dmem_addr;
    logic [1:0]  dmem_be;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        Stall_MEM, RegWrite_out, MemtoReg_out, R15_out;
    logic [15:0] WB_Data_out, Remainder_out;
    logic [3:0]  MEMWB_RegRD_out;
    logic        misalign_err, bus_err;

    int n_cmp;
    int n_fail;

    mem_wb_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .R15_in(R15_in), .RegWrite_in(RegWrite_in),
        .ALU_Result_in(ALU_Result_in), .ALU_Remainder_in(ALU_Remainder_in),
        .StoreData_in(StoreData_in), .movOp_in(movOp_in), .EXM_RegRD_in(EXM_RegRD_in),
        .FLUSH_MEM(FLUSH_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .Stall_MEM(Stall_MEM), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .R15_out(R15_out), .WB_Data_out(WB_Data_out), .Remainder_out(Remainder_out),
        .MEMWB_RegRD_out(MEMWB_RegRD_out), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: byte selection by arithmetic on the address and read data.
    function automatic logic [15:0] model_load(input logic [3:0] mov, input logic [15:0] addr,
                                               input logic [15:0] rdata);
        int b;
        b = (int'(addr) % 2 == 1) ? int'(rdata) / 256 : int'(rdata) % 256;
        if (mov == 4'd1) return 16'(b);
        if (mov == 4'd2) return (b >= 128) ? 16'(b + 65280) : 16'(b);
        return rdata;
    endfunction

    function automatic bit model_byte(input logic [3:0] mov);
        return (mov >= 4'd1) && (mov <= 4'd3);
    endfunction

    function automatic logic [1:0] model_be(input logic [3:0] mov, input logic [15:0] addr);
        if (!model_byte(mov)) return 2'd3;
        return (int'(addr) % 2 == 1) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [15:0] model_wdata(input logic [3:0] mov, input logic [15:0] sd);
        return (mov == 4'd3) ? 16'((int'(sd) % 256) * 257) : sd;
    endfunction

    task automatic set_instr(input logic rd_en, input logic wr_en, input logic to_reg,
                             input logic r15, input logic reg_wr, input logic [15:0] alu,
                             input logic [15:0] rem, input logic [15:0] sd,
                             input logic [3:0] mov, input logic [3:0] rd);
        MemRead_in = rd_en; MemWrite_in = wr_en; MemtoReg_in = to_reg; R15_in = r15;
        RegWrite_in = reg_wr; ALU_Result_in = alu; ALU_Remainder_in = rem;
        StoreData_in = sd; movOp_in = mov; EXM_RegRD_in = rd;
    endtask

    task automatic idle_inputs();
        set_instr(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0);
        FLUSH_MEM = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(1, 0, 1, 1, 1, 16'h5555, 16'h7777, 16'h0, 4'h0, 4'h9);
        FLUSH_MEM = 1'b0; dmem_ack = 1'b0; dmem_rdata = 16'hABCD;
        tick(); tick();
        n_cmp++; if (RegWrite_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_regwrite: got %b want 0", RegWrite_out); end
        n_cmp++; if (WB_Data_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_wbdata: got %h want 0000", WB_Data_out); end
        n_cmp++; if (R15_out !== 1'b0 || MemtoReg_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got r15=%b m2r=%b want 0", R15_out, MemtoReg_out); end
        n_cmp++; if (MEMWB_RegRD_out !== 4'h0 || Remainder_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_rd_rem: got %h/%h want 0", MEMWB_RegRD_out, Remainder_out); end
        n_cmp++; if (bus_err !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_errs: got bus=%b mis=%b want 0", bus_err, misalign_err); end
        idle_inputs();
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || Stall_MEM !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_stall: got req=%b stall=%b want 0", dmem_req, Stall_MEM); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        logic [15:0] alu, rem;
        logic [3:0]  rd;
        logic        rw, r15, fl;
        set_instr(0, 0, 0, 0, 1, 16'h1234, 16'h0, 16'h0, 4'h0, 4'h3);
        #1;
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_fail++; $display("[TB] FAIL add_stall: got %b want 0", Stall_MEM); end
        tick();
        n_cmp++; if (WB_Data_out !== 16'h1234 || RegWrite_out !== 1'b1 || MEMWB_RegRD_out !== 4'h3) begin n_fail++; $display("[TB] FAIL add_wb: got %h/%b/%h want 1234/1/3", WB_Data_out, RegWrite_out, MEMWB_RegRD_out); end
        for (int i = 0; i < 12; i++) begin
            alu = 16'($urandom); rem = 16'($urandom); rd = 4'($urandom);
            rw = 1'($urandom); r15 = 1'($urandom); fl = ($urandom_range(0, 3) == 0);
            set_instr(0, 0, 0, r15, rw, alu, rem, 16'($urandom), 4'h0, rd);
            FLUSH_MEM = fl;
            #1;
            n_cmp++; if (Stall_MEM !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_nostall: got stall=%b req=%b want 0", Stall_MEM, dmem_req); end
            tick();
            if (fl) begin
                n_cmp++; if (RegWrite_out !== 1'b0 || R15_out !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_flush_bubble: got rw=%b r15=%b want 0", RegWrite_out, R15_out); end
            end else begin
                n_cmp++; if (WB_Data_out !== alu || RegWrite_out !== rw || R15_out !== r15 || MEMWB_RegRD_out !== rd || Remainder_out !== rem) begin
                    n_fail++; $display("[TB] FAIL alu_pass: got %h/%b/%b/%h/%h want %h/%b/%b/%h/%h", WB_Data_out, RegWrite_out, R15_out, MEMWB_RegRD_out, Remainder_out, alu, rw, r15, rd, rem);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_load_fast();
        logic [15:0] addr, rdata;
        logic [3:0]  mov;
        set_instr(1, 0, 1, 0, 1, 16'h0011, 16'h0, 16'h0, 4'd2, 4'h5);
        dmem_ack = 1'b1; dmem_rdata = 16'h80AA;
        #1;
        n_cmp++; if (Stall_MEM !== 1'b0 || dmem_req !== 1'b1 || dmem_be !== 2'b10 || dmem_addr !== 15'h0008) begin n_fail++; $display("[TB] FAIL lb_fast_port: got stall=%b req=%b be=%b addr=%h want 0/1/10/0008", Stall_MEM, dmem_req, dmem_be, dmem_addr); end
        tick();
        n_cmp++; if (WB_Data_out !== 16'hFF80) begin n_fail++; $display("[TB] FAIL lb_fast_data: got %h want ff80", WB_Data_out); end
        movOp_in = 4'd1;
        tick();
        n_cmp++; if (WB_Data_out !== 16'h0080) begin n_fail++; $display("[TB] FAIL lbu_fast_data: got %h want 0080", WB_Data_out); end
        for (int i = 0; i < 16; i++) begin
            addr = 16'($urandom); rdata = 16'($urandom); mov = 4'($urandom);
            set_instr(1, 0, 1, 0, 1, addr, 16'h0, 16'h0, mov, 4'h7);
            dmem_ack = 1'b1; dmem_rdata = rdata;
            #1;
            n_cmp++; if (Stall_MEM !== 1'b0 || dmem_be !== model_be(mov, addr) || dmem_addr !== 15'(addr >> 1)) begin n_fail++; $display("[TB] FAIL load_fast_port: got stall=%b be=%b addr=%h want 0/%b/%h", Stall_MEM, dmem_be, dmem_addr, model_be(mov, addr), 15'(addr >> 1)); end
            tick();
            n_cmp++; if (WB_Data_out !== model_load(mov, addr, rdata) || RegWrite_out !== 1'b1) begin n_fail++; $display("[TB] FAIL load_fast_data: got %h/%b want %h/1 (mov=%h addr=%h)", WB_Data_out, RegWrite_out, model_load(mov, addr, rdata), mov, addr); end
            n_cmp++; if (misalign_err !== (!model_byte(mov) && addr[0])) begin n_fail++; $display("[TB] FAIL load_fast_misalign: got %b want %b", misalign_err, (!model_byte(mov) && addr[0])); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_delayed(input bit is_store, input logic [3:0] mov, input logic [15:0] addr,
                                input logic [15:0] sd, input int delay);
        logic [15:0] rdata;
        rdata = 16'($urandom);
        if (is_store) set_instr(0, 1, 0, 0, 0, addr, 16'h0, sd, mov, 4'h0);
        else          set_instr(1, 0, 1, 0, 1, addr, 16'h0, sd, mov, 4'hA);
        dmem_rdata = rdata;
        for (int k = 0; k <= delay; k++) begin
            dmem_ack = (k == delay);
            #1;
            n_cmp++; if (Stall_MEM !== (k < delay) || dmem_req !== 1'b1 || dmem_we !== is_store) begin n_fail++; $display("[TB] FAIL delayed_ctrl k=%0d: got stall=%b req=%b we=%b want %b/1/%b", k, Stall_MEM, dmem_req, dmem_we, (k < delay), is_store); end
            if (is_store) begin
                n_cmp++; if (dmem_be !== model_be(mov, addr) || dmem_wdata !== model_wdata(mov, sd)) begin n_fail++; $display("[TB] FAIL store_lanes: got be=%b wdata=%h want %b/%h", dmem_be, dmem_wdata, model_be(mov, addr), model_wdata(mov, sd)); end
            end
            tick();
            if (k < delay) begin
                n_cmp++; if (RegWrite_out !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_bubble k=%0d: got rw=%b want 0", k, RegWrite_out); end
            end
        end
        n_cmp++; if (RegWrite_out !== !is_store) begin n_fail++; $display("[TB] FAIL delayed_retire: got rw=%b want %b", RegWrite_out, !is_store); end
        if (!is_store) begin
            n_cmp++; if (WB_Data_out !== model_load(mov, addr, rdata) || MEMWB_RegRD_out !== 4'hA) begin n_fail++; $display("[TB] FAIL delayed_load_data: got %h/%h want %h/a", WB_Data_out, MEMWB_RegRD_out, model_load(mov, addr, rdata)); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        set_instr(1, 0, 1, 0, 1, 16'h0040, 16'h0, 16'h0, 4'h0, 4'h2);
        dmem_ack = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            #1;
            n_cmp++; if (Stall_MEM !== (k < 16) || dmem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_stall k=%0d: got stall=%b req=%b want %b/1", k, Stall_MEM, dmem_req, (k < 16)); end
            tick();
            n_cmp++; if (bus_err !== (k == 16) || RegWrite_out !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_buserr k=%0d: got bus=%b rw=%b want %b/0", k, bus_err, RegWrite_out, (k == 16)); end
        end
        idle_inputs();
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_req_drop: got %b want 0", dmem_req); end
        tick();
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_pulse: got %b want 0", bus_err); end
        set_instr(1, 0, 1, 0, 1, 16'h0042, 16'h0, 16'h0, 4'h0, 4'h2);
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        #1;
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_back_idle: got stall=%b want 0", Stall_MEM); end
        tick();
        n_cmp++; if (WB_Data_out !== 16'hBEEF || RegWrite_out !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_next_load: got %h/%b want beef/1", WB_Data_out, RegWrite_out); end
        idle_inputs();
    endtask

    task automatic test_flush();
        set_instr(1, 0, 1, 1, 1, 16'($urandom), 16'h0, 16'h0, 4'h0, 4'h4);
        dmem_rdata = 16'($urandom);
        for (int k = 0; k <= 4; k++) begin
            FLUSH_MEM = (k == 2);
            dmem_ack = (k == 4);
            #1;
            n_cmp++; if (Stall_MEM !== (k < 4) || dmem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_busy_ctrl k=%0d: got stall=%b req=%b want %b/1", k, Stall_MEM, dmem_req, (k < 4)); end
            tick();
        end
        FLUSH_MEM = 1'b0;
        n_cmp++; if (RegWrite_out !== 1'b0 || R15_out !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy_bubble: got rw=%b r15=%b want 0", RegWrite_out, R15_out); end
        set_instr(0, 0, 0, 0, 1, 16'h0F0F, 16'h0, 16'h0, 4'h0, 4'h6);
        dmem_ack = 1'b0;
        tick();
        n_cmp++; if (RegWrite_out !== 1'b1 || WB_Data_out !== 16'h0F0F) begin n_fail++; $display("[TB] FAIL flush_cleared: got %b/%h want 1/0f0f", RegWrite_out, WB_Data_out); end
        set_instr(0, 1, 0, 0, 1, 16'h0020, 16'h0, 16'h9999, 4'h0, 4'h6);
        FLUSH_MEM = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || Stall_MEM !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle_noreq: got req=%b stall=%b want 0", dmem_req, Stall_MEM); end
        tick();
        n_cmp++; if (RegWrite_out !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle_bubble: got %b want 0", RegWrite_out); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_busy();
        set_instr(1, 0, 1, 0, 1, 16'h0100, 16'h0, 16'h0, 4'h0, 4'h8);
        dmem_ack = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (Stall_MEM !== 1'b1) begin n_fail++; $display("[TB] FAIL rstbusy_pre: got stall=%b want 1", Stall_MEM); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (RegWrite_out !== 1'b0 || WB_Data_out !== 16'h0 || bus_err !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rstbusy_outputs: got %b/%h/%b/%b want 0", RegWrite_out, WB_Data_out, bus_err, misalign_err); end
        FLUSH_MEM = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rstbusy_idle: got req=%b want 0", dmem_req); end
        idle_inputs();
        tick();
        set_instr(1, 0, 1, 0, 1, 16'h0003, 16'h0, 16'h0, 4'h0, 4'h1);
        dmem_ack = 1'b1; dmem_rdata = 16'hC3A5;
        #1;
        n_cmp++; if (dmem_addr !== 15'h0001 || dmem_be !== 2'b11) begin n_fail++; $display("[TB] FAIL misalign_port: got addr=%h be=%b want 0001/11", dmem_addr, dmem_be); end
        tick();
        n_cmp++; if (misalign_err !== 1'b1 || WB_Data_out !== 16'hC3A5) begin n_fail++; $display("[TB] FAIL misalign_pulse: got %b/%h want 1/c3a5", misalign_err, WB_Data_out); end
        idle_inputs();
        tick();
        n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("[TB] FAIL misalign_clear: got %b want 0", misalign_err); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        idle_inputs();
        dmem_rdata = 16'h0;
        test_reset();
        test_alu();
        test_load_fast();
        test_delayed(1'b1, 4'd3, 16'h0010, 16'h1234, 3);
        test_delayed(1'b1, 4'd0, 16'($urandom), 16'($urandom), 2);
        for (int i = 0; i < 4; i++) begin
            test_delayed(1'b0, 4'($urandom_range(0, 3)), 16'($urandom), 16'h0, int'($urandom_range(1, 5)));
        end
        test_timeout();
        test_flush();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
